// File: rtl/debounce_pulse_gen.sv
// Debouncer for a raw bouncing button: synchronizer, 4-state qualifier FSM,
// registered level/edge-pulse outputs and a saturating count of aborted transitions.
module debounce_pulse_gen #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                btn_in,
   output logic                level_o,
   output logic                rise_pulse_o,
   output logic                fall_pulse_o,
   output logic                busy_o,
   output logic [GLITCH_W-1:0] glitch_cnt_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;
   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic                   level_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   busy_q;
   logic [GLITCH_W-1:0]    glitch_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
   assign s      = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // Pulses default low every cycle so they can only ever last one clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE_LOW;
         cnt_q    <= '0;
         level_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         busy_q   <= 1'b0;
         glitch_q <= '0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            IDLE_LOW: begin
               if (s) begin
                  state_q <= WAIT_HIGH;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state_q <= IDLE_LOW;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  if (glitch_q != '1) glitch_q <= glitch_q + 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE_HIGH;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            IDLE_HIGH: begin
               if (!s) begin
                  state_q <= WAIT_LOW;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(1);
               end
            end
            WAIT_LOW: begin
               if (s) begin
                  state_q <= IDLE_HIGH;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  if (glitch_q != '1) glitch_q <= glitch_q + 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE_LOW;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
                  fall_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE_LOW;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign level_o      = level_q;
   assign rise_pulse_o = rise_q;
   assign fall_pulse_o = fall_q;
   assign busy_o       = busy_q;
   assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Directed bench: press/bounce/release/reset-abort on one debouncer, glitch
// saturation on a narrow-counter copy, and a 4-bit count-enable integration.
module tb_debounce_pulse_gen;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn = 1'b0;
   logic       btn2 = 1'b0;
   logic       level, rise, fall, busy;
   logic [7:0] glitch;
   logic       level2, rise2, fall2, busy2;
   logic [1:0] glitch2;

   int         n_chk = 0;
   int         n_pass = 0;
   int         n_rise = 0;
   int         n_fall = 0;
   logic [3:0] cnt4;
   int         r0, f0;

   always #5 clk = ~clk;

   debounce_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .btn_in(btn),
      .level_o(level), .rise_pulse_o(rise), .fall_pulse_o(fall),
      .busy_o(busy), .glitch_cnt_o(glitch)
   );

   debounce_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(2)) u_dut_sat (
      .clk(clk), .reset_n(reset_n), .btn_in(btn2),
      .level_o(level2), .rise_pulse_o(rise2), .fall_pulse_o(fall2),
      .busy_o(busy2), .glitch_cnt_o(glitch2)
   );

   // Pulses span a full cycle, so sampling on the falling edge sees each once.
   always @(negedge clk) begin
      if (rise) n_rise <= n_rise + 1;
      if (fall) n_fall <= n_fall + 1;
   end

   // Downstream 4-bit counter with rise_pulse_o as its count enable.
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) cnt4 <= 4'd0;
      else if (rise) cnt4 <= cnt4 + 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      step(2);
      chk("rst_level", 32'(level), 0);
      chk("rst_rise", 32'(rise), 0);
      chk("rst_fall", 32'(fall), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_glitch", 32'(glitch), 0);
      chk("rst_glitch2", 32'(glitch2), 0);

      // clean press: release reset at edge 0, button high before edge 1
      reset_n = 1'b1;
      btn = 1'b1;
      step(2);
      chk("press_busy_e2", 32'(busy), 0);
      step(1);
      chk("press_busy_e3", 32'(busy), 1);
      step(2);
      chk("press_level_e5", 32'(level), 0);
      chk("press_rise_e5", 32'(rise), 0);
      step(1);
      chk("press_level_e6", 32'(level), 1);
      chk("press_rise_e6", 32'(rise), 1);
      chk("press_busy_e6", 32'(busy), 0);
      step(1);
      chk("press_rise_e7", 32'(rise), 0);
      chk("press_level_e7", 32'(level), 1);
      chk("press_glitch", 32'(glitch), 0);

      // release
      step(3);
      r0 = n_rise;
      btn = 1'b0;
      step(5);
      chk("rel_fall_e5", 32'(fall), 0);
      step(1);
      chk("rel_fall_e6", 32'(fall), 1);
      chk("rel_level_e6", 32'(level), 0);
      step(1);
      chk("rel_fall_e7", 32'(fall), 0);
      chk("rel_no_rise", 32'(n_rise - r0), 0);

      // bounce 1,0,1,0 every two cycles, then settle high
      step(3);
      r0 = n_rise;
      btn = 1'b1; step(2);
      btn = 1'b0; step(2);
      btn = 1'b1; step(2);
      btn = 1'b0; step(2);
      btn = 1'b1; step(10);
      chk("bounce_glitch", 32'(glitch), 2);
      chk("bounce_rises", 32'(n_rise - r0), 1);
      chk("bounce_level", 32'(level), 1);

      // reset while qualifying a fall
      btn = 1'b0;
      step(3);
      chk("rstq_busy", 32'(busy), 1);
      f0 = n_fall;
      reset_n = 1'b0;
      #1;
      chk("rstq_level", 32'(level), 0);
      chk("rstq_busy0", 32'(busy), 0);
      chk("rstq_rise", 32'(rise), 0);
      chk("rstq_fall", 32'(fall), 0);
      chk("rstq_glitch", 32'(glitch), 0);
      btn = 1'b1;
      step(3);
      reset_n = 1'b1;
      step(5);
      chk("rstq_rise_e5", 32'(rise), 0);
      step(1);
      chk("rstq_rise_e6", 32'(rise), 1);
      chk("rstq_no_fall", 32'(n_fall - f0), 0);

      // integration: 17 clean presses into the 4-bit counter
      reset_n = 1'b0;
      btn = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(4);
      r0 = n_rise;
      for (int i = 0; i < 17; i++) begin
         btn = 1'b1; step(8);
         btn = 1'b0; step(8);
      end
      chk("int_rises", 32'(n_rise - r0), 17);
      chk("int_cnt4", 32'(cnt4), 1);
      chk("int_glitch", 32'(glitch), 0);

      // one-sample glitches into the 2-bit glitch counter
      for (int i = 0; i < 5; i++) begin
         btn2 = 1'b1; step(1);
         btn2 = 1'b0; step(5);
         chk($sformatf("sat_glitch_%0d", i), 32'(glitch2), (i < 3) ? i + 1 : 3);
         chk($sformatf("sat_level_%0d", i), 32'(level2), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/debounce_pulse_gen.md
Name: debounce_pulse_gen

Overview:
- Conditions a raw, asynchronous, bouncing push-button or switch input into a clean level and single-cycle edge pulses.
- Sits directly upstream of the 4-bit counter built from d_flipflop stages. rise_pulse_o drives the counter's count-enable, so one physical press advances the count by exactly one.
- Also counts rejected bounce events to support lab debugging.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer chain; legal values are 2 or more.
- DEBOUNCE_CYCLES, 16, consecutive synchronized samples required to accept a new level; legal values are 2 or more.
- GLITCH_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  single system clock; all flops are rising-edge.
- reset_n  input  1  asynchronous, active-low reset; asserts immediately, is released by the system synchronously to clk.
- btn_in  input  1  raw asynchronous input; may bounce or glitch at any time.
- level_o  output  1  debounced stable level.
- rise_pulse_o  output  1  one-cycle pulse when level_o goes 0->1.
- fall_pulse_o  output  1  one-cycle pulse when level_o goes 1->0.
- busy_o  output  1  high while a candidate transition is being qualified.
- glitch_cnt_o  output  GLITCH_W  saturating count of aborted transitions.

Behaviour:
- Reset values:
  - All synchronizer flops are 0.
  - State is IDLE_LOW and the qualification counter cnt is 0.
  - level_o, rise_pulse_o, fall_pulse_o and busy_o are 0.
  - glitch_cnt_o is 0.
  - Reset asserted at any point, including mid-qualification, aborts immediately: no pulse is produced and the glitch count is not incremented.
- Synchronizer: s is btn_in delayed through SYNC_STAGES flops. s is the only signal the FSM reads; btn_in never feeds logic directly.
- Qualification counter: cnt is a $clog2(DEBOUNCE_CYCLES)-bit register.
- FSM has 4 states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All actions below take effect at a rising edge.
- IDLE_LOW:
  - If s=1: go to WAIT_HIGH, cnt<=1.
  - Otherwise hold.
- WAIT_HIGH:
  - If s=0: go to IDLE_LOW, cnt<=0, glitch_cnt_o increments.
  - Else if cnt==DEBOUNCE_CYCLES-1: go to IDLE_HIGH, level_o<=1, rise_pulse_o<=1, cnt<=0.
  - Else cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW mirror the above with polarity swapped; acceptance sets level_o<=0 and fall_pulse_o<=1.
- Pulses: rise_pulse_o and fall_pulse_o are registered and high for exactly one cycle. They are never high together, and never high in consecutive cycles.
- busy_o: 1 exactly when the state is WAIT_HIGH or WAIT_LOW; it is registered together with the state.
- Latency: btn_in goes high and stays high before rising edge 1. Then level_o and rise_pulse_o go high after edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 18 at defaults). rise_pulse_o clears at the next edge. Falling transitions have the same latency.
- Input pulses shorter than DEBOUNCE_CYCLES synchronized samples never change level_o.
- glitch_cnt_o saturates at 2^GLITCH_W-1 and does not wrap; only reset clears it.
- Power-up with btn_in already high: treated as a normal rise after reset release, so one rise_pulse_o is produced.

Test Plan:
- Setup: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, reset_n released at edge 0.
- Clean press: btn_in 0->1 before edge 1, then held -> busy_o=1 after edge 3; level_o=1 and rise_pulse_o=1 after edge 6; pulse=0 after edge 7; glitch_cnt_o=0.
- Bounce: btn_in toggles 1,0,1,0 every 2 cycles, then settles high -> exactly one rise_pulse_o; glitch_cnt_o equals the number of aborted WAIT_HIGH entries (2); level_o ends at 1.
- Release: from a stable high, btn_in 1->0 held -> fall_pulse_o for one cycle after edge 6 of the release; level_o=0; rise_pulse_o stays 0 throughout.
- Reset mid-qualification: reset_n=0 while busy_o=1 -> all outputs 0 immediately (asynchronously, before the next edge) and no pulse fires. Release reset with btn_in high -> rise_pulse_o after edge 6 from release.
- Saturation: with GLITCH_W=2, inject 5 one-sample glitches -> glitch_cnt_o reads 1,2,3,3,3 and level_o stays 0.
- Integration: drive rise_pulse_o into the 4-bit counter enable and make 17 clean presses -> counter reads 1 (wraps through 15 to 0, then 1).
